// File: rtl/mult_share_pkg.sv
// Shared definitions for the multiplier-sharing controller: FSM state
// encoding, operand/product widths, default watchdog limit and the sign
// correction helper.
package mult_share_pkg;

    localparam int OP_W        = 8;
    localparam int PROD_W      = 16;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Turn the multiplier's magnitude/sign pair into a two's complement
    // result; a zero magnitude with the sign set wraps back to zero.
    function automatic logic [PROD_W-1:0] apply_sign(input logic [PROD_W-1:0] mag,
                                                     input logic              neg);
        return neg ? (~mag + PROD_W'(1)) : mag;
    endfunction

endpackage

// File: rtl/mult_share_rr_arbiter.sv
// Round-robin arbiter: holds the priority pointer and selects the first
// requesting index at or above it, wrapping around.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [NREQ-1:0] req_i,
    input  logic            adv_i,
    input  logic [IDW-1:0]  adv_idx_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o,
    output logic            vld_o
);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;
    logic [IDW:0]   cand;

    // Rotate-priority search starting at the pointer.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!vld_o && req_i[cand[IDW-1:0]]) begin
                vld_o                = 1'b1;
                idx_o                = cand[IDW-1:0];
                gnt_o[cand[IDW-1:0]] = 1'b1;
            end
        end
    end

    // Next pointer is one past the granted index, wrapping at NREQ.
    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) begin
            ptr_d = (adv_idx_i == IDW'(NREQ-1)) ? '0 : adv_idx_i + IDW'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// Controller sharing one sequential signed 8x8 multiplier among NREQ
// requesters: round-robin grant, operand capture, start pulse, wait for
// done, sign correction and tagged result broadcast.
// Optional watchdog: define MULT_SHARE_TIMEOUT_EN to abort a BUSY phase
// after TIMEOUT cycles with resp_err set.
module mult_share_ctrl
    import mult_share_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [8*NREQ-1:0]    a_in,
    input  logic [8*NREQ-1:0]    b_in,
    output logic [NREQ-1:0]      ack,
    output logic                 mul_start,
    output logic [OP_W-1:0]      mul_a,
    output logic [OP_W-1:0]      mul_b,
    input  logic [PROD_W-1:0]    mul_product,
    input  logic                 mul_sign,
    input  logic                 mul_done,
    output logic                 resp_valid,
    output logic [IDW-1:0]       resp_id,
    output logic [PROD_W-1:0]    resp_product,
    output logic                 resp_err,
    output logic                 busy
);

    state_e              state_q, state_d;
    logic [OP_W-1:0]     mul_a_q, mul_b_q;
    logic [IDW-1:0]      id_q;
    logic [NREQ-1:0]     gnt_q;
    logic [PROD_W-1:0]   prod_q;
    logic [NREQ-1:0]     arb_gnt;
    logic [IDW-1:0]      arb_idx;
    logic                arb_vld;
    logic                grant_take;
    logic                done_take;
    logic                to_take;
    logic                adv;

    assign adv        = (state_q == ST_START);
    assign grant_take = (state_q == ST_IDLE) && arb_vld;
    assign done_take  = (state_q == ST_BUSY) && mul_done;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req_i     (req),
        .adv_i     (adv),
        .adv_idx_i (id_q),
        .gnt_o     (arb_gnt),
        .idx_o     (arb_idx),
        .vld_o     (arb_vld)
    );

`ifdef MULT_SHARE_TIMEOUT_EN
    logic [3:0] cnt_q;
    logic       err_q;

    assign to_take  = (state_q == ST_BUSY) && !mul_done && (cnt_q == 4'(TIMEOUT-1));
    assign resp_err = err_q;

    // BUSY cycle counter, cleared while the start pulse is out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == ST_START) begin
            cnt_q <= '0;
        end else if (state_q == ST_BUSY) begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    // Error flag travels with the captured result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (done_take) begin
            err_q <= 1'b0;
        end else if (to_take) begin
            err_q <= 1'b1;
        end
    end
`else
    assign to_take  = 1'b0;
    assign resp_err = 1'b0;
`endif

    // Next-state logic; mul_done only matters while in BUSY.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (arb_vld) state_d = ST_START;
            ST_START: state_d = ST_BUSY;
            ST_BUSY:  if (done_take || to_take) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand/grant capture at grant time, result capture on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a_q <= '0;
            mul_b_q <= '0;
            id_q    <= '0;
            gnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            if (grant_take) begin
                mul_a_q <= a_in[{arb_idx, 3'b000} +: OP_W];
                mul_b_q <= b_in[{arb_idx, 3'b000} +: OP_W];
                id_q    <= arb_idx;
                gnt_q   <= arb_gnt;
            end
            if (done_take) begin
                prod_q <= apply_sign(mul_product, mul_sign);
            end else if (to_take) begin
                prod_q <= '0;
            end
        end
    end

    assign mul_start    = (state_q == ST_START);
    assign ack          = mul_start ? gnt_q : '0;
    assign mul_a        = mul_a_q;
    assign mul_b        = mul_b_q;
    assign resp_valid   = (state_q == ST_RESP);
    assign resp_id      = id_q;
    assign resp_product = prod_q;
    assign busy         = (state_q != ST_IDLE);

endmodule
